// File: rtl/image_send_ctrl.sv
// One-shot frame transmit sequencer: captures a whole camera frame, freezes writes,
// lends the frame-buffer read port to image_sender and waits for its completion flag.
module image_send_ctrl #(
  parameter int          ADDR_W         = 17,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_req,
  input  logic              frame_start,
  input  logic              cam_wr_en_in,
  output logic              cam_wr_en_out,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [ADDR_W-1:0] snd_addr,
  output logic [ADDR_W-1:0] fb_rd_addr,
  output logic              snd_rst,
  input  logic              snd_done,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {IDLE, ARM, FILL, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic        pending, pending_nxt;
  logic        terr_nxt;
  logic [31:0] timer, timer_nxt;
  logic        snd_done_q;
  logic        done_edge;
  logic        timer_hit;

  // snd_done_q is held high while image_sender is in reset, so a flag left over
  // from a previous transfer never looks like a rising edge on SEND entry.
  assign done_edge = snd_done & ~snd_done_q;
  assign timer_hit = (timer == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= 1'b0;
      timer       <= '0;
      snd_done_q  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      timer       <= timer_nxt;
      snd_done_q  <= snd_rst ? 1'b1 : snd_done;
      timeout_err <= terr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending | (send_req & (state != IDLE));
    terr_nxt      = timeout_err;
    timer_nxt     = '0;
    busy          = (state != IDLE);
    done          = (state == DONE);
    snd_rst       = (state != SEND);
    fb_rd_addr    = (state == SEND) ? snd_addr : disp_addr;
    // Freeze starts on the frame_start that ends the captured frame, not a cycle later.
    cam_wr_en_out = cam_wr_en_in & ~((state == SEND) | ((state == FILL) & frame_start));

    case (state)
      IDLE: begin
        if (send_req | pending) begin
          state_nxt   = ARM;
          pending_nxt = 1'b0;
          terr_nxt    = 1'b0;
        end
      end
      ARM:  if (frame_start) state_nxt = FILL;
      FILL: if (frame_start) state_nxt = SEND;
      SEND: begin
        if (done_edge) begin
          state_nxt = DONE;
        end else if (timer_hit) begin
          terr_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = (timer == 32'hFFFF_FFFF) ? timer : timer + 32'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_send_ctrl.sv
// Randomized and scenario-driven bench for image_send_ctrl against a transfer-phase
// reference model; outputs are compared every cycle on the falling edge.
module tb_image_send_ctrl;

  localparam int AW  = 17;
  localparam int TMO = 1000;

  logic          clk = 1'b0;
  logic          rst, send_req, frame_start, cam_wr_en_in, snd_done;
  logic [AW-1:0] disp_addr, snd_addr;
  logic          cam_wr_en_out, snd_rst, busy, done, timeout_err;
  logic [AW-1:0] fb_rd_addr;

  image_send_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(32'd1000)) dut (
    .clk(clk), .rst(rst), .send_req(send_req), .frame_start(frame_start),
    .cam_wr_en_in(cam_wr_en_in), .cam_wr_en_out(cam_wr_en_out),
    .disp_addr(disp_addr), .snd_addr(snd_addr), .fb_rd_addr(fb_rd_addr),
    .snd_rst(snd_rst), .snd_done(snd_done), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for a fresh frame, 2 capturing it,
  // 3 transmitting, 4 finishing. m_el counts transmit cycles so far.
  int ph = 0, n_ph;
  bit m_pend = 0, m_terr = 0, m_prev = 1;
  bit n_pend, n_terr, n_prev;
  int m_el = 0, n_el;

  int mode = 0, kick = 0, rst_hold = 3, fs_cnt = 0, xfers = 0;
  int dut_done = 0, dut_send = 0;

  task automatic model_reset();
    ph = 0; m_pend = 0; m_terr = 0; m_el = 0; m_prev = 1;
  endtask

  task automatic check_outputs();
    chk("busy",    busy,          (ph != 0));
    chk("done",    done,          (ph == 4));
    chk("snd_rst", snd_rst,       (ph != 3));
    chk("fb_addr", fb_rd_addr,    (ph == 3) ? snd_addr : disp_addr);
    chk("wr_en",   cam_wr_en_out, ((ph == 3) || (ph == 2 && frame_start)) ? 1'b0 : cam_wr_en_in);
    chk("terr",    timeout_err,   m_terr);
  endtask

  task automatic model_next();
    n_ph = ph; n_pend = m_pend | (send_req && ph != 0); n_terr = m_terr; n_el = 0; n_prev = 1;
    if (!rst) begin
      n_ph = 0; n_pend = 0; n_terr = 0;
    end else begin
      case (ph)
        0: if (send_req || m_pend) begin n_ph = 1; n_pend = 0; n_terr = 0; end
        1: if (frame_start) n_ph = 2;
        2: if (frame_start) n_ph = 3;
        3: begin
          if (snd_done && !m_prev) n_ph = 4;
          else if (m_el == TMO - 1) begin n_terr = 1; n_ph = 0; end
          else begin n_el = m_el + 1; n_prev = snd_done; end
        end
        default: begin n_ph = 0; xfers++; end
      endcase
    end
  endtask

  task automatic drive();
    send_req     = 1'b0;
    disp_addr    = AW'($urandom);
    snd_addr     = AW'($urandom);
    cam_wr_en_in = 1'($urandom_range(0, 1));
    fs_cnt++;
    frame_start  = (fs_cnt % 20 == 0);
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst = 1'b1;
    end
    if (kick != 0) begin send_req = 1'b1; kick = 0; end
    case (mode)
      0: begin
        if ($urandom_range(0, 59) == 0) send_req = 1'b1;
        frame_start = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 19) == 0) snd_done = ~snd_done;
      end
      1: snd_done = 1'b0;
      2: snd_done = (ph == 3) ? !(m_el >= 10 && m_el < 50) : 1'b1;
      3: begin
        snd_done = (ph == 3 && m_el >= 30);
        if (ph == 3 && xfers == 0 && (m_el == 5 || m_el == 8)) send_req = 1'b1;
      end
      default: begin
        snd_done = 1'b0;
        if (ph == 3 && m_el == 3) send_req = 1'b1;
        if (ph == 3 && m_el == 20 && rst) begin
          #2 rst = 1'b0;
          #1;
          chk("async_snd_rst", snd_rst, 1'b1);
          chk("async_fb_addr", fb_rd_addr, disp_addr);
          chk("async_busy",    busy, 1'b0);
          chk("async_wr_en",   cam_wr_en_out, cam_wr_en_in);
          model_reset();
          rst_hold = 3;
        end
      end
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      if (done) dut_done++;
      if (!snd_rst) dut_send++;
      model_next();
      @(posedge clk);
      ph = n_ph; m_pend = n_pend; m_terr = n_terr; m_el = n_el; m_prev = n_prev;
      #1 drive();
    end
  endtask

  task automatic start_phase(input int m);
    mode = m; kick = 1; xfers = 0; dut_done = 0; dut_send = 0; fs_cnt = 0;
  endtask

  initial begin
    rst = 1'b0; send_req = 1'b0; frame_start = 1'b0; cam_wr_en_in = 1'b1;
    snd_done = 1'b0; disp_addr = '0; snd_addr = '0;

    // random traffic, including reset-state checks while rst is low
    mode = 0;
    run(20000);
    mode = 1; kick = 0; snd_done = 1'b0;
    run(2200);
    chk("drain_idle", busy, 1'b0);

    // timeout: exactly TMO transmit cycles, no done pulse
    start_phase(1);
    run(1200);
    chk("tmo_send_cycles", dut_send, TMO);
    chk("tmo_done_count",  dut_done, 0);
    chk("tmo_err_sticky",  timeout_err, 1'b1);
    chk("tmo_idle",        busy, 1'b0);

    // stale completion flag: only the rise at transmit cycle 50 completes
    start_phase(2);
    run(200);
    chk("stale_send_cycles", dut_send, 51);
    chk("stale_done_count",  dut_done, 1);
    chk("stale_err_cleared", timeout_err, 1'b0);

    // two extra requests during transmit collapse into one extra transfer
    start_phase(3);
    run(400);
    chk("queue_done_count", dut_done, 2);
    chk("queue_idle",       busy, 1'b0);

    // asynchronous reset mid-transmit drops the queued request
    start_phase(4);
    run(300);
    chk("rst_done_count", dut_done, 0);
    chk("rst_no_service", busy, 1'b0);
    chk("rst_snd_rst",    snd_rst, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_send_ctrl.md
Name: image_send_ctrl

Overview:
- Sequences one-shot transmission of a captured frame over UART.
- Sits between the camera write path, the frame-buffer read port and image_sender.
- On a send request, it waits for a complete frame to land in the buffer, freezes camera writes, and hands the read port to image_sender.
- It releases image_sender from reset, waits for its completion flag, then returns the read port to the display.

Parameters:
- ADDR_W, 17, frame-buffer address width.
- TIMEOUT_CYCLES, 32'd50_000_000, maximum SEND duration in clk cycles before abort.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-low reset
- send_req  in  1  single-cycle request pulse (debounced button)
- frame_start  in  1  single-cycle pulse at start of each camera frame
- cam_wr_en_in  in  1  camera frame-buffer write enable
- cam_wr_en_out  out  1  gated write enable to frame buffer
- disp_addr  in  ADDR_W  display read address
- snd_addr  in  ADDR_W  image_sender read address
- fb_rd_addr  out  ADDR_W  frame-buffer read address
- snd_rst  out  1  active-high reset to image_sender
- snd_done  in  1  image_sender image_ready, level
- busy  out  1  high in any state except IDLE
- done  out  1  single-cycle pulse on successful completion
- timeout_err  out  1  sticky; set on SEND timeout, cleared by next accepted send_req

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pending=0, timer=0, snd_done_q=0.
  - Outputs: snd_rst=1, busy=0, done=0, timeout_err=0.
  - cam_wr_en_out follows cam_wr_en_in; fb_rd_addr=disp_addr.
- States: IDLE, ARM, FILL, SEND, DONE.
- IDLE:
  - If send_req or pending: clear pending and timeout_err, go to ARM next cycle.
- ARM:
  - Wait for frame_start, then go to FILL.
  - Purpose: writes of the in-progress partial frame are discarded, and the next frame is written whole.
- FILL:
  - Writes pass through.
  - On the next frame_start, go to SEND.
  - Freeze begins in the same cycle as that frame_start: cam_wr_en_out=0 combinationally whenever state==FILL and frame_start==1, and whenever state==SEND.
- SEND:
  - snd_rst=0, fb_rd_addr=snd_addr.
  - timer increments each cycle from 0.
  - snd_done_q registers snd_done.
  - Rising edge (snd_done & ~snd_done_q): go to DONE.
  - timer==TIMEOUT_CYCLES-1 without an edge: set timeout_err=1 and go to IDLE. No done pulse.
  - A snd_done already high on SEND entry is not an edge. snd_done_q is forced to 1 while snd_rst=1, so a stale flag cannot complete a transfer.
- DONE:
  - done=1 for exactly one cycle; snd_rst=1; writes unfrozen; go to IDLE.
- Outside SEND:
  - snd_rst=1, fb_rd_addr=disp_addr, timer=0.
  - cam_wr_en_out=cam_wr_en_in, except the FILL/frame_start cycle above.
- Read-port mux:
  - Combinational from the registered state only; no added latency on addresses.
- Request queue:
  - send_req while busy sets pending (one deep; further requests are dropped).
  - Pending is serviced from IDLE on the cycle after DONE or timeout.
- Simultaneous events:
  - send_req in the same cycle as the DONE→IDLE transition sets pending.
  - frame_start on the ARM entry cycle is not counted; ARM waits for a frame_start while in ARM.
- Reset mid-SEND:
  - Immediately asserts snd_rst, restores writes and display address, and drops pending.
- Timer:
  - 32 bits, saturating; compare is equality.

Test Plan:
- Normal send, TIMEOUT_CYCLES=1000:
  - Stimulus: reset; send_req at t=100ns; frame_start pulses every 200 cycles; snd_done rises 300 cycles after snd_rst falls.
  - busy rises the next cycle.
  - cam_wr_en_out is 0 from the 2nd frame_start after the request until the DONE cycle.
  - fb_rd_addr tracks snd_addr during SEND and disp_addr otherwise.
  - done is one cycle wide; busy=0 the cycle after.
- Stale done: hold snd_done=1 before and into SEND, drop at cycle 10, raise at 50 → DONE only after the cycle-50 rise.
- Timeout, TIMEOUT_CYCLES=1000: snd_done held 0 → after exactly 1000 SEND cycles, timeout_err=1, state IDLE, no done, snd_rst=1.
- Queued request: second send_req during SEND, third during SEND → exactly one additional ARM/FILL/SEND sequence after the first done, then IDLE.
- Async reset mid-SEND: drive rst=0 between clock edges → snd_rst=1 and fb_rd_addr=disp_addr before the next edge; busy=0; no pending service after release.
- Freeze edge: frame_start in FILL with cam_wr_en_in=1 → cam_wr_en_out=0 in that same cycle.
